// File: rtl/eight_to_one_scan_pkg.sv
// Shared definitions for the eight-channel scan collector: channel codes,
// scan state encoding and the default data width.
package eight_to_one_scan_pkg;

    localparam logic [3:0] CH_NONE  = 4'b0000;
    localparam logic [3:0] CH_FIRST = 4'b0001;
    localparam logic [3:0] CH_LAST  = 4'b1000;

    localparam int DW_DEFAULT = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } scan_state_e;

endpackage

// File: rtl/eight_to_one_scan_settle_cnt.sv
// Settle-time counter: counts up from zero after a clear and flags when the
// programmed terminal value is reached, then holds there.
module scan_settle_cnt #(
    parameter logic [3:0] TERM = 4'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt_q, cnt_d;

    assign tc = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eight_to_one_scan.sv
// Sequential 8-to-1 collector: steps choice through channels 1..8, waits SETTLE
// cycles per channel, captures the word and hands it out on valid/ready.
// Define EIGHT_SCAN_LOOP_EN to keep scanning continuously while start is held.
module eight_to_one_scan
    import eight_to_one_scan_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int DW     = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic [DW-1:0] data4,
    input  logic [DW-1:0] data5,
    input  logic [DW-1:0] data6,
    input  logic [DW-1:0] data7,
    input  logic [DW-1:0] data8,
    input  logic          out_ready,
    output logic [3:0]    choice,
    output logic [DW-1:0] dataout,
    output logic [3:0]    ch_tag,
    output logic          data_valid,
    output logic          busy,
    output logic          done
);

    scan_state_e   state_q, state_d;
    logic [3:0]    choice_q, choice_d;
    logic [3:0]    ch_tag_q, ch_tag_d;
    logic [DW-1:0] dataout_q, dataout_d;
    logic          data_valid_q, data_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] sel_data;
    logic          cnt_clr, cnt_en, cnt_tc;

    scan_settle_cnt #(
        .TERM(4'(SETTLE))
    ) u_settle_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    always_comb begin
        case (choice_q)
            4'd1:    sel_data = data1;
            4'd2:    sel_data = data2;
            4'd3:    sel_data = data3;
            4'd4:    sel_data = data4;
            4'd5:    sel_data = data5;
            4'd6:    sel_data = data6;
            4'd7:    sel_data = data7;
            4'd8:    sel_data = data8;
            default: sel_data = '0;
        endcase
    end

    // Capture is folded into the SETTLE exit edge, so S_CAPTURE is never entered.
    always_comb begin
        state_d      = state_q;
        choice_d     = choice_q;
        ch_tag_d     = ch_tag_q;
        dataout_d    = dataout_q;
        data_valid_d = data_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    choice_d = CH_FIRST;
                    busy_d   = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_tc) begin
                    dataout_d    = sel_data;
                    ch_tag_d     = choice_q;
                    data_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (data_valid_q && out_ready) begin
                    data_valid_d = 1'b0;
                    if (choice_q != CH_LAST) begin
                        choice_d = choice_q + 4'd1;
                        cnt_clr  = 1'b1;
                        state_d  = S_SETTLE;
                    end else begin
                        done_d = 1'b1;
`ifdef EIGHT_SCAN_LOOP_EN
                        if (start) begin
                            choice_d = CH_FIRST;
                            cnt_clr  = 1'b1;
                            state_d  = S_SETTLE;
                        end else begin
                            choice_d = CH_NONE;
                            busy_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
`else
                        choice_d = CH_NONE;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                choice_d     = CH_NONE;
                data_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            choice_q     <= CH_NONE;
            ch_tag_q     <= CH_NONE;
            dataout_q    <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            choice_q     <= choice_d;
            ch_tag_q     <= ch_tag_d;
            dataout_q    <= dataout_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign choice     = choice_q;
    assign dataout    = dataout_q;
    assign ch_tag     = ch_tag_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
